mat_mem_arbiter: RTL and testbench
==================================

MAT_MEM_ARBITER -- requirements
Module: mat_mem_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, memory data width.
REQ-002 SHALL have parameter AW, default 17, memory address width (matches [m+n:0] with m=n=8).
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per grant while the other requester waits.
REQ-004 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset input 1: synchronous, active-high reset.
REQ-006 SHALL have ports req0/req1 input 1 each: access request; req0 is the host loader, req1 is the multiply controller.
REQ-007 SHALL have ports we0/we1 input 1 each, addr0/addr1 input AW each, and wdata0/wdata1 input DW each: per-requester beat command.
REQ-008 SHALL have ports gnt0/gnt1 output 1 each: registered grant, one-hot or zero.
REQ-009 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output AW, and mem_wdata output DW: the shared memory port.
REQ-010 SHALL have port mem_rdata input DW: memory read data, valid one cycle after a read beat.
REQ-011 SHALL have ports rdata output DW (mem_rdata passthrough) and rdata_vld0/rdata_vld1 output 1 each: read-return strobes.

Function
REQ-012 SHALL implement states IDLE, OWN0 and OWN1; gnt0=1 only in OWN0 and gnt1=1 only in OWN1.
REQ-013 SHALL, in IDLE with exactly one req high at edge N, enter the matching OWN state, so the grant is visible in cycle N+1.
REQ-014 SHALL, in IDLE with both reqs high, grant the requester not granted most recently (round-robin pointer last).
REQ-015 SHALL define a beat as any cycle with gntX=1 and reqX=1; in a beat, mem_en=1 and mem_we/mem_addr/mem_wdata equal weX/addrX/wdataX combinationally.
REQ-016 SHALL drive mem_en=0 and mem_we=0 in non-beat cycles; mem_addr and mem_wdata are don't-care then.
REQ-017 SHALL count beats per grant in a burst counter that clears on every grant change.
REQ-018 SHALL, when the owner drops req at cycle K (no beat in K), move at edge K+1 to the other OWN state if that requester is requesting, else to IDLE, so no idle bubble occurs on handover.
REQ-019 SHALL, when the burst counter reaches MAX_BURST and the other requester is requesting, switch ownership at that edge; the preempted requester sees gnt fall and must hold its command until re-granted.
REQ-020 SHALL, when the burst counter reaches MAX_BURST and the other requester is idle, clear the counter and retain ownership.
REQ-021 SHALL update last to the owner on every entry to an OWN state.
REQ-022 SHALL pulse rdata_vldX for exactly one cycle, in the cycle after each read beat (weX=0) of requester X, even if the grant changed in between.
REQ-023 SHALL never assert gnt0 and gnt1 together, nor rdata_vld0 and rdata_vld1 together.

Reset
REQ-024 SHALL, while reset=1 at an edge, set state=IDLE, gnt0=gnt1=0, rdata_vld0=rdata_vld1=0, burst counter=0 and last=1 (req0 wins the first tie).
REQ-025 SHALL give reset priority over all requests, including a reset asserted mid-burst; a pending read return is discarded.

Configuration
REQ-026 SHALL, with MAT_ARB_FIXED_PRIO_EN defined, resolve every tie in IDLE to requester 1 while REQ-019 preemption still applies; without the macro, round-robin per REQ-014.

Structure
REQ-027 SHALL place the state enum, the default DW/AW/MAX_BURST constants and the requester index constants in shared package mat_arb_pkg.
REQ-028 SHALL implement the burst counter (count, clear, terminal flag) as sub-module arb_burst_cnt, width $clog2(MAX_BURST+1).

Verification
REQ-029 SHALL cover: reset, then req0=1 only at cycle 2 -> gnt0=1 at cycle 3; write beat addr0=5, wdata0=0xA5 -> mem_en=1, mem_we=1, mem_addr=5, mem_wdata=0xA5 in that cycle.
REQ-030 SHALL cover: both reqs high from IDLE after reset -> gnt0 first; after req0 drops, gnt1 the next cycle with no bubble; next tie -> gnt0 (round-robin).
REQ-031 SHALL cover: MAX_BURST=4 with req0 held and req1 high -> exactly 4 beats for req0, then gnt1; with req1 low -> req0 keeps the grant beyond 4 beats.
REQ-032 SHALL cover: read beat by req1 at addr 9 with mem_rdata=0x3C next cycle -> rdata_vld1=1 and rdata=0x3C for one cycle, rdata_vld0=0.
REQ-033 SHALL cover: reset asserted mid-burst at beat 2 -> next cycle gnt0=gnt1=0, mem_en=0, rdata_vld both 0.
REQ-034 SHALL cover: build with MAT_ARB_FIXED_PRIO_EN, repeated ties -> gnt1 wins each tie.

Source files
------------

// File: rtl/mat_arb_pkg.sv
// rtl/mat_arb_pkg.sv - shared types and constants for the matrix memory arbiter
//
// Holds the arbiter state encoding, default memory geometry and burst limit,
// and the requester indices (0 = host loader, 1 = multiply controller).
package mat_arb_pkg;

    localparam int ARB_DW        = 8;
    localparam int ARB_AW        = 17;
    localparam int ARB_MAX_BURST = 16;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_MUL  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Ownership state belonging to a requester index.
    function automatic arb_state_e own_state(input logic idx);
        return (idx == REQ_MUL) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/arb_burst_cnt.sv
// rtl/arb_burst_cnt.sv - per-grant beat counter with terminal flag
//
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : clear the count at the next edge (wins over inc_i)
//   inc_i          : a beat occurs this cycle
//   term_o         : this beat brings the count to MAX_BURST
module arb_burst_cnt #(
    parameter int MAX_BURST = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Flagged on the beat that would make the count MAX_BURST, so the owner
    // decision is taken at the same edge that retires that beat.
    assign term_o = inc_i && (cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mat_mem_arbiter.sv
// rtl/mat_mem_arbiter.sv - two-requester arbiter for a shared single-port memory
//
// Requester 0 is the host loader, requester 1 the multiply controller.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   reqX/weX/addrX/wdataX      : per-requester beat command (held until granted)
//   gntX                       : registered grant, one-hot or zero
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata : shared memory port
//   rdata, rdata_vldX          : read data and one-cycle read-return strobes
// Build option: MAT_ARB_FIXED_PRIO_EN makes requester 1 win every IDLE tie;
// otherwise ties go round-robin.
module mat_mem_arbiter
    import mat_arb_pkg::*;
#(
    parameter int DW        = ARB_DW,
    parameter int AW        = ARB_AW,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          rdata_vld0,
    output logic          rdata_vld1
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       rvld0_q, rvld1_q;
    logic       beat0, beat1;
    logic       burst_term;
    logic       tie_win;

    assign beat0 = (state_q == ST_OWN0) && req0;
    assign beat1 = (state_q == ST_OWN1) && req1;

`ifdef MAT_ARB_FIXED_PRIO_EN
    assign tie_win = REQ_MUL;
`else
    assign tie_win = (last_q == REQ_MUL) ? REQ_HOST : REQ_MUL;
`endif

    // Any change of owner (including to IDLE) restarts the burst; reaching
    // the limit with nobody waiting also restarts it so the owner keeps going.
    arb_burst_cnt #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   ((state_d != state_q) || burst_term),
        .inc_i   (beat0 || beat1),
        .term_o  (burst_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_MUL;
            rvld0_q <= 1'b0;
            rvld1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rvld0_q <= beat0 && !we0;
            rvld1_q <= beat1 && !we1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = own_state(tie_win);
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            // Dropping req hands straight over to a waiting requester so no
            // idle cycle is inserted between owners.
            ST_OWN0: begin
                if (!req0) begin
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end else if (burst_term && req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end else if (burst_term && req0) begin
                    state_d = ST_OWN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        last_d = last_q;
        if ((state_d != state_q) && (state_d != ST_IDLE)) begin
            last_d = (state_d == ST_OWN1) ? REQ_MUL : REQ_HOST;
        end
    end

    always_comb begin
        gnt0      = (state_q == ST_OWN0);
        gnt1      = (state_q == ST_OWN1);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (beat0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (beat1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign rdata      = mem_rdata;
    assign rdata_vld0 = rvld0_q;
    assign rdata_vld1 = rvld1_q;

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// tb/tb_mat_mem_arbiter.sv - directed self-checking bench for mat_mem_arbiter
module tb_mat_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 17;
    localparam int MB = 4;

`ifdef MAT_ARB_FIXED_PRIO_EN
    localparam logic TIE_W = 1'b1;
`else
    localparam logic TIE_W = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = '0;
    logic [1:0]    we = '0;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic          gnt0, gnt1, mem_en, mem_we, rdata_vld0, rdata_vld1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem_model [32];
    logic [DW-1:0] ref_mem [32];

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } rd_exp_t;
    rd_exp_t rd_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mat_mem_arbiter #(
        .DW        (DW),
        .AW        (AW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req[0]),
        .req1       (req[1]),
        .we0        (we[0]),
        .we1        (we[1]),
        .addr0      (addr[0]),
        .addr1      (addr[1]),
        .wdata0     (wdata[0]),
        .wdata1     (wdata[1]),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rdata      (rdata),
        .rdata_vld0 (rdata_vld0),
        .rdata_vld1 (rdata_vld1)
    );

    // Memory behind the arbiter: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_model[mem_addr[4:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem_model[mem_addr[4:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [1:0] exp);
        chk(tag, {30'd0, gnt1, gnt0}, {30'd0, exp});
    endtask

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        we    = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Read-return scoreboard and per-cycle exclusivity checks.
    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
            chk("vld_exclusive", {31'd0, rdata_vld0 & rdata_vld1}, 32'd0);
            if (rdata_vld0 || rdata_vld1) begin
                if (rd_q.size() == 0) begin
                    chk("vld_unexpected", {30'd0, rdata_vld1, rdata_vld0}, 32'd0);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    chk("rd_id", {31'd0, rdata_vld1}, {31'd0, e.id});
                    chk("rd_data", {24'd0, rdata}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_model[i] = 8'(8'h40 + i);
            ref_mem[i]   = 8'(8'h40 + i);
        end
        mem_model[9] = 8'h3C;
        ref_mem[9]   = 8'h3C;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        // Reset state
        tick();
        tick();
        chk_gnt("rst_gnt", 2'b00);
        chk("rst_vld", {30'd0, rdata_vld1, rdata_vld0}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        reset = 1'b0;

        // Single requester write beat
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 17'd5; wdata[0] = 8'hA5;
        #1;
        chk_gnt("t1_pre_gnt", 2'b00);
        chk("t1_pre_en", {31'd0, mem_en}, 32'd0);
        tick();
        chk_gnt("t1_gnt", 2'b01);
        chk("t1_en", {31'd0, mem_en}, 32'd1);
        chk("t1_we", {31'd0, mem_we}, 32'd1);
        chk("t1_addr", {15'd0, mem_addr}, 32'd5);
        chk("t1_wdata", {24'd0, mem_wdata}, 32'hA5);
        ref_mem[5] = 8'hA5;
        tick();
        req[0] = 1'b0; we[0] = 1'b0;
        #1;
        chk("t1_nonbeat_en", {31'd0, mem_en}, 32'd0);
        chk("t1_nonbeat_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk_gnt("t1_idle", 2'b00);

        // Read back the written word through requester 1
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 17'd5;
        tick();
        chk_gnt("t1_rb_gnt", 2'b10);
        chk("t1_rb_en", {31'd0, mem_en}, 32'd1);
        rd_q.push_back('{id: 1'b1, data: ref_mem[5]});
        tick();
        req[1] = 1'b0;
        chk("t1_rb_vld1", {31'd0, rdata_vld1}, 32'd1);
        chk("t1_rb_data", {24'd0, rdata}, 32'hA5);
        tick();
        chk("t1_rb_vld1_off", {31'd0, rdata_vld1}, 32'd0);

        // Tie arbitration and handover without bubble
        do_reset();
        req = 2'b11; we = 2'b11;
        addr[0] = 17'd1; wdata[0] = 8'h11;
        addr[1] = 17'd2; wdata[1] = 8'h22;
        tick();
        chk_gnt("t2_tie1", oh(TIE_W));
        chk("t2_tie1_addr", {15'd0, mem_addr}, {15'd0, addr[TIE_W]});
        tick();
        req[TIE_W] = 1'b0;
        #1;
        chk("t2_drop_en", {31'd0, mem_en}, 32'd0);
        tick();
        chk_gnt("t2_handover", oh(!TIE_W));
        chk("t2_handover_addr", {15'd0, mem_addr}, {15'd0, addr[!TIE_W]});
        tick();
        req[!TIE_W] = 1'b0;
        ref_mem[1] = 8'h11;
        ref_mem[2] = 8'h22;
        tick();
        chk_gnt("t2_idle", 2'b00);
        req = 2'b11;
        tick();
        chk_gnt("t2_tie2", oh(TIE_W));
        req = 2'b00;
        tick();
        chk_gnt("t2_idle2", 2'b00);

        // Burst limit: preempt after MB beats, retain when other side idle
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 17'd12; wdata[0] = 8'h77;
        ref_mem[12] = 8'h77;
        tick();
        chk_gnt("t3_own0", 2'b01);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 17'd13; wdata[1] = 8'h88;
        for (int i = 0; i < MB; i++) begin
            chk_gnt($sformatf("t3_beat%0d", i), 2'b01);
            tick();
        end
        chk_gnt("t3_preempt", 2'b10);
        req[1] = 1'b0;
        tick();
        chk_gnt("t3_back0", 2'b01);
        for (int i = 0; i < MB + 2; i++) begin
            chk_gnt($sformatf("t3_keep%0d", i), 2'b01);
            tick();
        end
        // Counter wrapped at MB, so two more beats finish this burst.
        req[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk_gnt($sformatf("t3_tail%0d", i), 2'b01);
            tick();
        end
        chk_gnt("t3_preempt2", 2'b10);
        req = 2'b00;
        tick();
        chk_gnt("t3_idle", 2'b00);

        // Read return to requester 1
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 17'd9;
        tick();
        chk_gnt("t4_gnt1", 2'b10);
        chk("t4_rd_en", {31'd0, mem_en}, 32'd1);
        chk("t4_rd_we", {31'd0, mem_we}, 32'd0);
        chk("t4_rd_addr", {15'd0, mem_addr}, 32'd9);
        rd_q.push_back('{id: 1'b1, data: ref_mem[9]});
        tick();
        req[1] = 1'b0;
        chk("t4_vld1", {31'd0, rdata_vld1}, 32'd1);
        chk("t4_vld0", {31'd0, rdata_vld0}, 32'd0);
        chk("t4_rdata", {24'd0, rdata}, 32'h3C);
        tick();
        chk("t4_vld1_once", {31'd0, rdata_vld1}, 32'd0);

        // Read strobe survives a grant change at the same edge
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 17'd5;
        tick();
        chk_gnt("t4_own0", 2'b01);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 17'd12;
        for (int i = 0; i < MB; i++) begin
            rd_q.push_back('{id: 1'b0, data: ref_mem[5]});
            tick();
        end
        chk_gnt("t4_preempt_rd", 2'b10);
        chk("t4_vld0_after_switch", {31'd0, rdata_vld0}, 32'd1);
        req[0] = 1'b0;
        rd_q.push_back('{id: 1'b1, data: ref_mem[12]});
        tick();
        req[1] = 1'b0;
        chk("t4_vld1_b", {31'd0, rdata_vld1}, 32'd1);
        chk("t4_vld0_b", {31'd0, rdata_vld0}, 32'd0);
        tick();
        chk_gnt("t4_idle", 2'b00);

        // Reset mid-burst discards the in-flight read
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 17'd20; wdata[0] = 8'h5A;
        tick();
        chk_gnt("t5_own0", 2'b01);
        tick();
        ref_mem[20] = 8'h5A;
        we[0] = 1'b0; addr[0] = 17'd9;
        reset = 1'b1;
        tick();
        chk_gnt("t5_rst_gnt", 2'b00);
        chk("t5_rst_en", {31'd0, mem_en}, 32'd0);
        chk("t5_rst_vld", {30'd0, rdata_vld1, rdata_vld0}, 32'd0);
        reset = 1'b0;
        req = 2'b00;
        tick();
        chk_gnt("t5_after_gnt", 2'b00);
        chk("t5_after_vld", {30'd0, rdata_vld1, rdata_vld0}, 32'd0);
        tick();

        chk("scoreboard_empty", rd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
